bcd_digit_streamer: RTL and testbench

//  Multi-digit decade (BCD) counter with a snapshot-and-stream output port.

---
 rtl/bcd_digit_streamer_if.sv | 11 +
 rtl/bcd_digit_streamer.sv | 120 ++++++++++++
 tb/tb_bcd_digit_streamer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_streamer_if.sv
// Digit stream channel between the BCD counter streamer and its downstream consumer.
// The master drives one BCD digit per transfer; the slave returns ready.
interface bcd_digit_streamer_if;
    logic [3:0] dig;
    logic       dig_valid;
    logic       dig_last;
    logic       dig_ready;

    modport master (output dig, output dig_valid, output dig_last, input dig_ready);
    modport slave  (input dig, input dig_valid, input dig_last, output dig_ready);
endinterface

// File: rtl/bcd_digit_streamer.sv
// Multi-digit BCD counter that can snapshot its value and stream it out
// one digit per handshake, most significant digit first.
module bcd_digit_streamer #(
    parameter int NDIG = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cnt_en,
    input  logic                   load,
    input  logic [4*NDIG-1:0]      load_val,
    input  logic                   start,
    bcd_digit_streamer_if.master   ds,
    output logic                   busy,
    output logic [4*NDIG-1:0]      count,
    output logic                   carry_out,
    output logic                   load_err
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] snapshot;

    // Nibbles above 9 cannot be represented in BCD; they load as 0.
    function automatic logic [4*NDIG-1:0] sanitize(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [4*NDIG-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Ripple increment; the MSB of the result is the wrap carry.
    function automatic logic [4*NDIG:0] bcd_inc(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        logic              c;
        logic [3:0]        n;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            n = v[4*i +: 4];
            if (c) begin
                if (n == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = n + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            carry_out <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                count    <= sanitize(load_val);
                load_err <= has_bad(load_val);
            end else if (cnt_en) begin
                {carry_out, count} <= bcd_inc(count);
            end
        end
    end

    // Snapshot takes the pre-edge count, so same-cycle load/increment is excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= IDX_W'(NDIG - 1);
            snapshot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= count;
                        idx      <= IDX_W'(NDIG - 1);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (ds.dig_ready) begin
                        if (idx == '0) state <= IDLE;
                        else           idx   <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ds.dig       = 4'd0;
        ds.dig_valid = (state == SEND);
        ds.dig_last  = (state == SEND) && (idx == '0);
        busy         = (state == SEND);
        if (state == SEND) begin
            for (int i = 0; i < NDIG; i++) begin
                if (idx == IDX_W'(i)) ds.dig = snapshot[4*i +: 4];
            end
        end
    end
endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Directed bench for bcd_digit_streamer: a table of single-cycle counter
// operations plus hand-written streaming sequences.
module tb_bcd_digit_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cnt_en;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        busy;
    logic [15:0] count;
    logic        carry_out;
    logic        load_err;

    int total = 0;
    int passed = 0;

    bcd_digit_streamer_if ds ();

    bcd_digit_streamer #(.NDIG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .ds        (ds.master),
        .busy      (busy),
        .count     (count),
        .carry_out (carry_out),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        cnt_en;
        logic [15:0] load_val;
        logic [15:0] exp_count;
        logic        exp_carry;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_stream(input string name, input logic [3:0] d, input logic last);
        chk({name, " valid"}, {15'd0, ds.dig_valid}, 16'd1);
        chk({name, " busy"}, {15'd0, busy}, 16'd1);
        chk({name, " dig"}, {12'd0, ds.dig}, {12'd0, d});
        chk({name, " last"}, {15'd0, ds.dig_last}, {15'd0, last});
    endtask

    task automatic chk_idle(input string name);
        chk({name, " valid"}, {15'd0, ds.dig_valid}, 16'd0);
        chk({name, " busy"}, {15'd0, busy}, 16'd0);
        chk({name, " dig"}, {12'd0, ds.dig}, 16'd0);
        chk({name, " last"}, {15'd0, ds.dig_last}, 16'd0);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    logic [3:0] exp_dig [4];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h9998, 16'h9998, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0000, 16'h9999, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'hA3F1, 16'h0301, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0302, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'h0199, 16'h0199, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h0200, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0909, 16'h0909, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0910, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0910, 1'b0, 1'b0};

        rst = 1'b1; cnt_en = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
        ds.dig_ready = 1'b0;
        tick(); tick();
        chk("reset count", count, 16'h0000);
        chk("reset carry", {15'd0, carry_out}, 16'd0);
        chk("reset load_err", {15'd0, load_err}, 16'd0);
        chk_idle("reset");
        rst = 1'b0;

        // 12 increments from zero
        cnt_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("inc12 carry", {15'd0, carry_out}, 16'd0);
        end
        cnt_en = 1'b0;
        chk("inc12 count", count, 16'h0012);

        for (int i = 0; i < 12; i++) begin
            load = vecs[i].load; cnt_en = vecs[i].cnt_en; load_val = vecs[i].load_val;
            tick();
            chk($sformatf("vec%0d count", i), count, vecs[i].exp_count);
            chk($sformatf("vec%0d carry", i), {15'd0, carry_out}, {15'd0, vecs[i].exp_carry});
            chk($sformatf("vec%0d load_err", i), {15'd0, load_err}, {15'd0, vecs[i].exp_err});
        end
        load = 1'b0; cnt_en = 1'b0;

        // Stream 1234 with ready held high; start overlapping the final transfer
        do_load(16'h1234);
        exp_dig = '{4'd1, 4'd2, 4'd3, 4'd4};
        start = 1'b1; ds.dig_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_stream($sformatf("s1234 d%0d", k), exp_dig[k], k == 3);
            if (k == 3) start = 1'b1;
            tick();
        end
        start = 1'b0;
        chk_idle("s1234 end");
        tick();
        chk_idle("s1234 no restart");

        // Stream 0507 with ready toggling while the counter runs
        do_load(16'h0507);
        exp_dig = '{4'd0, 4'd5, 4'd0, 4'd7};
        ds.dig_ready = 1'b0; start = 1'b1; cnt_en = 1'b1;
        tick();
        start = 1'b0;
        chk("s0507 count after start", count, 16'h0508);
        for (int k = 0; k < 4; k++) begin
            ds.dig_ready = 1'b0;
            chk_stream($sformatf("s0507 d%0d", k), exp_dig[k], k == 3);
            tick();
            chk_stream($sformatf("s0507 hold d%0d", k), exp_dig[k], k == 3);
            ds.dig_ready = 1'b1;
            tick();
        end
        cnt_en = 1'b0; ds.dig_ready = 1'b0;
        chk_idle("s0507 end");
        chk("s0507 count", count, 16'h0516);

        // Start during SEND is ignored and the snapshot is unaffected by a load
        do_load(16'h0301);
        exp_dig = '{4'd0, 4'd3, 4'd0, 4'd1};
        start = 1'b1;
        tick();
        load = 1'b1; load_val = 16'h0999;
        tick();
        load = 1'b0; start = 1'b0;
        chk("s0301 count", count, 16'h0999);
        ds.dig_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_stream($sformatf("s0301 d%0d", k), exp_dig[k], k == 3);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk_idle($sformatf("s0301 after%0d", k));
            tick();
        end

        // Reset mid-frame aborts the stream
        do_load(16'h4321);
        start = 1'b1; ds.dig_ready = 1'b1;
        tick();
        start = 1'b0;
        chk_stream("abort d0", 4'd4, 1'b0);
        tick();
        chk_stream("abort d1", 4'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort rst");
        chk("abort count", count, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_idle($sformatf("abort after%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
